// File: rtl/pipe_flopenr_chain_if.sv
// Handshake bundle for pipe_flopenr_chain: upstream push side, downstream pop side,
// flush and occupancy. Optional stall_cnt exists only with PIPE_CHAIN_STALL_CNT_EN.
interface pipe_flopenr_chain_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  // A word moves on a clock edge where valid and ready are both 1 in the cycle
  // before it; valid and data must stay stable while valid=1 and ready=0.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CW-1:0]    count;
`ifdef PIPE_CHAIN_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  // master: the environment around the chain (producer, consumer, flush source)
  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
`ifdef PIPE_CHAIN_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  // slave: the chain itself
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
`ifdef PIPE_CHAIN_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/pipe_flopenr_chain.sv
// DEPTH-stage stallable, flushable register chain with bubble collapsing and an
// occupancy count. Optional stall counter enabled by PIPE_CHAIN_STALL_CNT_EN.
module pipe_flopenr_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_flopenr_chain_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH:0]   w_acc;
  logic [DEPTH-1:0] w_src_v;
  logic [WIDTH-1:0] w_src_d [DEPTH];
  logic             w_in_xfer;
  logic             w_out_xfer;

  // A stage may load when it or any stage downstream of it is empty, or the
  // consumer pops; this is a DEPTH-deep OR path from out_ready to in_ready.
  assign w_acc[DEPTH] = bus.out_ready;
  for (genvar i = 0; i < DEPTH; i++) begin : g_acc
    assign w_acc[i] = bus.out_ready | ~(&r_v[DEPTH-1:i]);
  end

  always_comb begin
    w_src_v[0] = bus.in_valid;
    w_src_d[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_v[i] = r_v[i-1];
      w_src_d[i] = r_d[i-1];
    end
  end

  assign bus.in_ready  = w_acc[0] & ~bus.flush;
  assign bus.out_valid = r_v[DEPTH-1] & ~bus.flush;
  assign bus.out_data  = r_d[DEPTH-1];
  assign bus.count     = r_count;

  assign w_in_xfer  = bus.in_valid & bus.in_ready;
  assign w_out_xfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v     <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= '0;
    end else if (bus.flush) begin
      r_v     <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_acc[i]) begin
          r_v[i] <= w_src_v[i];
          // data only moves with a valid source so empty stages keep their last word
          if (w_src_v[i]) r_d[i] <= w_src_d[i];
        end
      end
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef PIPE_CHAIN_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

  a_count_max: assert property (@(posedge clk) disable iff (!reset)
    r_count <= CW'(DEPTH));

  a_count_tracks_valid: assert property (@(posedge clk) disable iff (!reset)
    r_count == CW'($countones(r_v)));

endmodule

// File: tb/tb_pipe_flopenr_chain.sv
// Directed bench for pipe_flopenr_chain (WIDTH=32, DEPTH=3): accepted words go into
// an expected queue, a negedge monitor pops and compares every output transfer.
module tb_pipe_flopenr_chain;
  localparam int W = 32;
  localparam int D = 3;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [W-1:0] exp_q[$];

  pipe_flopenr_chain_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pipe_flopenr_chain #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_word: got %h required no transfer", bus.out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          n_fail++;
          $display("FAIL out_word: got %h required %h", bus.out_data, e);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] data, input bit expect_out);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (expect_out) exp_q.push_back(data);
        done = 1'b1;
      end
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_empty();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      if (bus.count == 0 && exp_q.size() == 0) done = 1'b1;
      else step();
    end
    if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // 1. reset and latency
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_data",  bus.out_data,       32'd0);
    reset = 1'b1;
    step();
    check("rel_in_ready",  32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    send(32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("lat_c1_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_c2_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_c3_out_valid", 32'(bus.out_valid), 32'd1);
    check("lat_c3_out_data",  bus.out_data,       32'hDEADBEEF);
    step();
    wait_empty();

    // 2. fill under stall
    bus.out_ready = 1'b0;
    send(32'hDEADBEEF, 1'b1);
    check("fill_count1", 32'(bus.count), 32'd1);
    send(32'hCAFEBABE, 1'b1);
    check("fill_count2", 32'(bus.count), 32'd2);
    send(32'h12345678, 1'b1);
    check("fill_count3",   32'(bus.count),    32'd3);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hAAAA5555;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    check("full_count_hold", 32'(bus.count), 32'd3);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_empty();
    step();
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("empty_data_hold", bus.out_data,       32'h12345678);

    // 3. streaming
    for (int k = 0; k < 10; k++) begin
      send(32'(k), 1'b1);
      if (k >= 2) begin
        check("stream_count",     32'(bus.count),     32'd3);
        check("stream_out_valid", 32'(bus.out_valid), 32'd1);
      end
    end
    wait_empty();

    // 4. bubble collapse
    bus.out_ready = 1'b0;
    send(32'h0000_00A1, 1'b1);
    step();
    send(32'h0000_00B2, 1'b1);
    step();
    check("bub_count",     32'(bus.count),     32'd2);
    check("bub_in_ready",  32'(bus.in_ready),  32'd1);
    check("bub_out_valid", 32'(bus.out_valid), 32'd1);
    check("bub_out_data",  bus.out_data,       32'h0000_00A1);
    check("bub_stage_v",   32'(dut.r_v),       32'b110);
    check("bub_stage1_d",  dut.r_d[1],         32'h0000_00B2);
    bus.out_ready = 1'b1;
    wait_empty();

    // 5. flush from full
    bus.out_ready = 1'b0;
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    send(32'h3333_3333, 1'b0);
    check("pre_flush_count", 32'(bus.count), 32'd3);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h4444_4444;
    bus.out_ready = 1'b1;
    #1;
    check("flush_in_ready",  32'(bus.in_ready),  32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("post_flush_count",     32'(bus.count),     32'd0);
    check("post_flush_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (4) step();
    check("flush_no_word", 32'(bus.count), 32'd0);
    check("flush_q_empty", 32'(exp_q.size()), 32'd0);

    // 6. mid-operation reset
    bus.out_ready = 1'b0;
    send(32'h5555_0001, 1'b0);
    send(32'h5555_0002, 1'b0);
    step();
    check("inflight_count",     32'(bus.count),     32'd2);
    check("inflight_out_valid", 32'(bus.out_valid), 32'd1);
    check("inflight_out_data",  bus.out_data,       32'h5555_0001);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_count",     32'(bus.count),     32'd0);
    check("midrst_out_data",  bus.out_data,       32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    step();
    reset = 1'b1;
    step();
`ifdef PIPE_CHAIN_STALL_CNT_EN
    check("stall_after_rst", bus.stall_cnt, 32'd0);
    send(32'h7777_0007, 1'b1);
    for (int t = 0; t < 10 && !bus.out_valid; t++) step();
    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (5) step();
    check("stall_cnt5", bus.stall_cnt, 32'd5);
    bus.out_ready = 1'b1;
    wait_empty();
    check("stall_hold", bus.stall_cnt, 32'd5);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("stall_no_flush_clr", bus.stall_cnt, 32'd5);
`endif
    bus.out_ready = 1'b1;
    wait_empty();
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
